// File: rtl/rng_pkg.sv
// Shared types and constants for the random-byte sequencer and its FIFO.
package rng_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RST_GEN = 2'd1,
        WAIT    = 2'd2
    } state_t;

    localparam byte_t SEED_DEFAULT = 8'h01;

    // The generator locks up on an all-zero seed, so zero is mapped to the default.
    function automatic byte_t nonzero_seed(input byte_t value);
        return (value == 8'h00) ? SEED_DEFAULT : value;
    endfunction

endpackage

// File: rtl/rng_fifo_mem.sv
// Show-ahead circular byte FIFO: storage, wrapping pointers, occupancy and full flag.
module rng_fifo_mem
    import rng_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [7:0]             head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    byte_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == FULL_COUNT);
    assign count     = count_reg;
    assign head_data = mem[rd_ptr_reg];

    // Guards keep the pointers coherent even if a caller misbehaves.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/rng_byte_fifo.sv
// Sequencer that repeatedly resets, seeds and runs the random generator and buffers
// every finished byte; each generation is seeded from the previous output.
module rng_byte_fifo
    import rng_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic                   enable,
    input  logic                   seed_load,
    input  logic [7:0]             seed_in,
    input  logic                   sel_in,
    output logic                   gen_reset,
    output logic                   gen_en,
    output logic                   gen_sel,
    output logic [7:0]             gen_seed,
    input  logic                   gen_valid,
    input  logic [7:0]             gen_rand,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   timeout_err,
    input  logic                   clear_err
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t         state_reg;
    state_t         state_next;
    logic [TW-1:0]  timer_reg;
    byte_t          seed_reg;
    logic           sel_reg;
    logic           err_reg;
    logic           capture;
    logic           expire;
    logic           fifo_full;
    logic           fifo_empty;

    // gen_valid only counts while waiting; a stale done from the generator is ignored.
    assign capture = (state_reg == WAIT) && gen_valid;
    assign expire  = (state_reg == WAIT) && !gen_valid && (timer_reg == TIMER_LAST);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gen_reset  = 1'b0;
        gen_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable && !fifo_full) begin
                    state_next = RST_GEN;
                end
            end
            RST_GEN: begin
                gen_reset  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                gen_en = 1'b1;
                if (capture || expire) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            timer_reg <= '0;
            sel_reg   <= 1'b0;
        end else begin
            if (state_reg == RST_GEN) begin
                timer_reg <= '0;
                sel_reg   <= sel_in;
            end else if (state_reg == WAIT) begin
                timer_reg <= timer_reg + 1'b1;
            end
        end
    end

    // An explicit seed load overrides re-seeding from a byte captured in the same cycle.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            seed_reg <= SEED_DEFAULT;
        end else if (seed_load) begin
            seed_reg <= nonzero_seed(seed_in);
        end else if (capture) begin
            seed_reg <= nonzero_seed(gen_rand);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_reg <= 1'b0;
        end else if (expire) begin
            err_reg <= 1'b1;
        end else if (clear_err) begin
            err_reg <= 1'b0;
        end
    end

    rng_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_L   (reset_L),
        .push      (capture),
        .push_data (gen_rand),
        .pop       (out_ready),
        .head_data (out_data),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign gen_sel     = sel_reg;
    assign gen_seed    = seed_reg;
    assign out_valid   = !fifo_empty;
    assign full        = fifo_full;
    assign timeout_err = err_reg;

endmodule

// File: tb/tb_rng_byte_fifo.sv
// Randomized bench for rng_byte_fifo: a scripted generator model plus a queue-based
// reference of the buffer, seed chain, timing and error flag.
module tb_rng_byte_fifo;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 32;

    logic       clk;
    logic       reset_L;
    logic       enable;
    logic       seed_load;
    logic [7:0] seed_in;
    logic       sel_in;
    logic       gen_reset;
    logic       gen_en;
    logic       gen_sel;
    logic [7:0] gen_seed;
    logic       gen_valid;
    logic [7:0] gen_rand;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] count;
    logic       full;
    logic       timeout_err;
    logic       clear_err;

    rng_byte_fifo #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .enable      (enable),
        .seed_load   (seed_load),
        .seed_in     (seed_in),
        .sel_in      (sel_in),
        .gen_reset   (gen_reset),
        .gen_en      (gen_en),
        .gen_sel     (gen_sel),
        .gen_seed    (gen_seed),
        .gen_valid   (gen_valid),
        .gen_rand    (gen_rand),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .full        (full),
        .timeout_err (timeout_err),
        .clear_err   (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_starts = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] fix_seed(input logic [7:0] v);
        return (v == 8'h00) ? 8'h01 : v;
    endfunction

    // ---------------- generator model ----------------
    int         cfg_lat = 11;
    logic [7:0] script_q[$];
    int         gen_cnt;
    int         gen_lat;
    logic [7:0] gen_byte;

    initial begin
        gen_valid = 1'b0;
        gen_rand  = 8'h00;
        gen_cnt   = 0;
        gen_lat   = 1;
        gen_byte  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_L) begin
                gen_valid = 1'b0;
                gen_cnt   = 0;
            end else if (gen_reset) begin
                gen_valid = 1'b0;
                gen_cnt   = 0;
                if (cfg_lat != 0)
                    gen_lat = cfg_lat;
                else if ($urandom_range(0, 9) == 0)
                    gen_lat = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
                else
                    gen_lat = $urandom_range(1, 20);
                if (script_q.size() != 0)
                    gen_byte = script_q.pop_front();
                else if ($urandom_range(0, 7) == 0)
                    gen_byte = 8'h00;
                else
                    gen_byte = 8'($urandom_range(0, 255));
            end else if (gen_en && !gen_valid) begin
                gen_cnt++;
                if (gen_cnt == gen_lat) begin
                    gen_valid = 1'b1;
                    gen_rand  = gen_byte;
                end
            end
            if (!gen_valid) gen_rand = 8'($urandom_range(0, 255));
        end
    end

    // ---------------- reference model / monitor ----------------
    logic [7:0] model_q[$];
    logic [7:0] exp_seed  = 8'h01;
    logic       exp_err   = 1'b0;
    logic       exp_sel   = 1'b0;
    int         wait_cnt  = 0;
    logic       prev_start = 1'b0;
    logic       prev_rst   = 1'b0;
    logic       prev_en    = 1'b0;
    logic       prev_leave = 1'b0;

    initial begin
        logic do_pop, do_push, tmo, start;
        forever begin
            @(negedge clk);
            if (!reset_L) begin
                model_q.delete();
                exp_seed   = 8'h01;
                exp_err    = 1'b0;
                exp_sel    = 1'b0;
                wait_cnt   = 0;
                prev_start = 1'b0;
                prev_rst   = 1'b0;
                prev_en    = 1'b0;
                prev_leave = 1'b0;
            end else begin
                check("count", 32'(count), model_q.size());
                check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
                check("full", 32'(full), 32'(model_q.size() == DEPTH));
                if (model_q.size() != 0) check("out_data", 32'(out_data), 32'(model_q[0]));
                check("timeout_err", 32'(timeout_err), 32'(exp_err));
                check("gen_seed", 32'(gen_seed), 32'(exp_seed));
                check("gen_reset", 32'(gen_reset), 32'(prev_start));
                check("gen_en", 32'(gen_en), 32'(prev_rst || (prev_en && !prev_leave)));
                if (gen_en) check("gen_sel", 32'(gen_sel), 32'(exp_sel));
                if (gen_reset) begin
                    exp_sel = sel_in;
                    n_starts++;
                end
                // Effects of the coming clock edge.
                start   = !gen_en && !gen_reset && enable && (model_q.size() < DEPTH);
                do_pop  = out_ready && (model_q.size() != 0);
                do_push = gen_en && gen_valid;
                wait_cnt = gen_en ? wait_cnt + 1 : 0;
                tmo     = gen_en && !gen_valid && (wait_cnt == TIMEOUT);
                if (do_pop) void'(model_q.pop_front());
                if (do_push) begin
                    model_q.push_back(gen_rand);
                    $display("push %02h  occupancy %0d", gen_rand, model_q.size());
                end
                if (tmo) $display("timeout after %0d wait cycles", wait_cnt);
                if (seed_load)    exp_seed = fix_seed(seed_in);
                else if (do_push) exp_seed = fix_seed(gen_rand);
                if (tmo)            exp_err = 1'b1;
                else if (clear_err) exp_err = 1'b0;
                prev_start = start;
                prev_rst   = gen_reset;
                prev_en    = gen_en;
                prev_leave = do_push || tmo;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pop_one();
        @(posedge clk); #2 out_ready = 1'b1;
        @(posedge clk); #2 out_ready = 1'b0;
    endtask

    task automatic wait_start(input int limit);
        bit found = 0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (gen_reset) found = 1;
        end
        if (!found) check("start_seen", 0, 1);
    endtask

    task automatic wait_full(input int limit);
        bit found = 0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (full) found = 1;
        end
        if (!found) check("fill_done", 0, 1);
    endtask

    initial begin
        int starts_snap;
        bit found;
        reset_L   = 1'b0;
        enable    = 1'b0;
        seed_load = 1'b0;
        seed_in   = 8'h00;
        sel_in    = 1'b0;
        out_ready = 1'b0;
        clear_err = 1'b0;
        #23;
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_full", 32'(full), 0);
        check("rst_gen_en", 32'(gen_en), 0);
        check("rst_gen_reset", 32'(gen_reset), 0);
        check("rst_gen_seed", 32'(gen_seed), 32'h01);
        check("rst_gen_sel", 32'(gen_sel), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        @(posedge clk); #2 reset_L = 1'b1;

        // Fill with scripted bytes and no consumer.
        script_q.push_back(8'hA5);
        script_q.push_back(8'h3C);
        sel_in = 1'b1;
        enable = 1'b1;
        wait_full(600);
        check("fill_count", 32'(count), DEPTH);
        check("fill_head", 32'(out_data), 32'hA5);
        starts_snap = n_starts;
        repeat (20) @(negedge clk);
        check("no_start_when_full", n_starts, starts_snap);

        // One pop triggers exactly one refill.
        pop_one();
        wait_full(100);
        check("one_refill", n_starts, starts_snap + 1);

        // Zero byte is buffered as-is but seeds the next run with 01.
        script_q.push_back(8'h00);
        pop_one();
        wait_full(100);
        script_q.push_back(8'h5A);
        pop_one();
        wait_start(100);
        check("zero_reseed", 32'(gen_seed), 32'h01);

        // seed_load coinciding with a capture of 5A wins.
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #2;
            if (gen_en && gen_valid) found = 1;
        end
        if (!found) check("capture_seen", 0, 1);
        seed_in   = 8'hC3;
        seed_load = 1'b1;
        @(posedge clk); #2 seed_load = 1'b0;
        pop_one();
        wait_start(100);
        check("seed_load_wins", 32'(gen_seed), 32'hC3);
        wait_full(100);

        // Silent generator: timeout, no push, then a retry.
        cfg_lat = 1000;
        pop_one();
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (timeout_err) found = 1;
        end
        check("timeout_set", 32'(timeout_err), 1);
        check("timeout_no_push", 32'(count), DEPTH - 1);
        wait_start(10);
        enable = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (!gen_en && !gen_reset) found = 1;
        end
        if (!found) check("idle_seen", 0, 1);
        @(posedge clk); #2 clear_err = 1'b1;
        @(posedge clk); #2 clear_err = 1'b0;
        check("timeout_cleared", 32'(timeout_err), 0);
        cfg_lat = 0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            out_ready = ($urandom_range(0, 1) == 1);
            enable    = ($urandom_range(0, 9) != 0);
            seed_load = ($urandom_range(0, 29) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            sel_in    = ($urandom_range(0, 1) == 1);
            clear_err = ($urandom_range(0, 49) == 0);
        end
        @(posedge clk); #2;
        seed_load = 1'b0;
        clear_err = 1'b0;
        out_ready = 1'b0;
        enable    = 1'b1;
        cfg_lat   = 11;
        if (full) pop_one();

        // Asynchronous reset in the middle of a generation.
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk); #2;
            if (gen_en && count != 0) found = 1;
        end
        if (!found) check("mid_wait_seen", 0, 1);
        #1 reset_L = 1'b0;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_gen_en", 32'(gen_en), 0);
        check("arst_gen_reset", 32'(gen_reset), 0);
        check("arst_seed", 32'(gen_seed), 32'h01);
        check("arst_err", 32'(timeout_err), 0);
        @(negedge clk);
        @(posedge clk); #2 reset_L = 1'b1;
        wait_start(10);
        wait_full(300);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
